// File: rtl/pe_ctx_pkg.sv
// Shared definitions for the PE context sequencer: field map, legal codes, state, NOP bundle.
// PE_CTX_ILLEGAL_CHK_EN enables issue-time legality checking of context words.
package pe_ctx_pkg;

    localparam int IN_LSB   = 0,  IN_MSB   = 8;
    localparam int OUT_LSB  = 9,  OUT_MSB  = 17;
    localparam int PUTI_LSB = 18, PUTI_MSB = 23;
    localparam int PUTO_LSB = 24, PUTO_MSB = 29;
    localparam int SEND_LSB = 30, SEND_MSB = 35;
    localparam int REG1_LSB = 36, REG1_MSB = 41;
    localparam int REG2_LSB = 42, REG2_MSB = 47;
    localparam int FU1_LSB  = 48, FU1_MSB  = 51;
    localparam int FU2_LSB  = 52, FU2_MSB  = 55;
    localparam int WB_BIT   = 56;
    localparam int LD_BIT   = 57;
    localparam int LDW_BIT  = 58;

    localparam logic [8:0] IN_NONE = 9'h000;
    localparam logic [8:0] IN_A    = 9'h008;
    localparam logic [8:0] IN_B    = 9'h004;
    localparam logic [8:0] IN_C    = 9'h002;
    localparam logic [8:0] IN_D    = 9'h010;

    localparam logic [3:0] FU_NONE = 4'b0000;
    localparam logic [3:0] FU_A    = 4'b0010;
    localparam logic [3:0] FU_B    = 4'b0011;
    localparam logic [3:0] FU_C    = 4'b0100;
    localparam logic [3:0] FU_D    = 4'b1000;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [8:0] control_in;
        logic [8:0] control_out;
        logic [5:0] put_in;
        logic [5:0] put_out;
        logic [5:0] send;
        logic [5:0] reg_1;
        logic [5:0] reg_2;
        logic [3:0] pe2fu_1;
        logic [3:0] pe2fu_2;
        logic       write_back;
        logic       ld;
        logic       ld_write;
    } ctx_bundle_t;

    localparam ctx_bundle_t NOP_BUNDLE = '{
        control_in: 9'd0, control_out: 9'd0, put_in: 6'd0, put_out: 6'd0,
        send: 6'd0, reg_1: 6'd0, reg_2: 6'd0, pe2fu_1: 4'd0, pe2fu_2: 4'd0,
        write_back: 1'b0, ld: 1'b1, ld_write: 1'b0};

    function automatic logic is_legal_in(input logic [8:0] c);
        return c inside {IN_NONE, IN_A, IN_B, IN_C, IN_D};
    endfunction

    function automatic logic is_legal_fu(input logic [3:0] c);
        return c inside {FU_NONE, FU_A, FU_B, FU_C, FU_D};
    endfunction

endpackage

// File: rtl/pe_ctx_decode.sv
// Combinational unpack of a 64-bit context word into the PE control bundle.
// With PE_CTX_ILLEGAL_CHK_EN, words with unknown mux/operand codes collapse to NOP.
import pe_ctx_pkg::*;

module pe_ctx_decode (
    input  logic [63:0] word,
    output ctx_bundle_t bundle
`ifdef PE_CTX_ILLEGAL_CHK_EN
    ,
    output logic        illegal
`endif
);

    ctx_bundle_t raw;
    logic [4:0]  unused_rsvd;

    assign unused_rsvd     = word[63:59];
    assign raw.control_in  = word[IN_MSB:IN_LSB];
    assign raw.control_out = word[OUT_MSB:OUT_LSB];
    assign raw.put_in      = word[PUTI_MSB:PUTI_LSB];
    assign raw.put_out     = word[PUTO_MSB:PUTO_LSB];
    assign raw.send        = word[SEND_MSB:SEND_LSB];
    assign raw.reg_1       = word[REG1_MSB:REG1_LSB];
    assign raw.reg_2       = word[REG2_MSB:REG2_LSB];
    assign raw.pe2fu_1     = word[FU1_MSB:FU1_LSB];
    assign raw.pe2fu_2     = word[FU2_MSB:FU2_LSB];
    assign raw.write_back  = word[WB_BIT];
    assign raw.ld          = word[LD_BIT];
    assign raw.ld_write    = word[LDW_BIT];

`ifdef PE_CTX_ILLEGAL_CHK_EN
    assign illegal = !is_legal_in(raw.control_in) || !is_legal_fu(raw.pe2fu_1)
                     || !is_legal_fu(raw.pe2fu_2);
    assign bundle  = illegal ? NOP_BUNDLE : raw;
`else
    assign bundle  = raw;
`endif

endmodule

// File: rtl/pe_ctx_seq.sv
// Context sequencer for one PE: stores a kernel of context words and replays one per cycle.
// Optional PE_CTX_ILLEGAL_CHK_EN adds the ctx_illegal output and NOP substitution.
import pe_ctx_pkg::*;

module pe_ctx_seq #(
    parameter int CTX_DEPTH = 16,
    parameter int CTX_AW    = 4,
    parameter int LOOP_W    = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cfg_we,
    input  logic [CTX_AW-1:0] cfg_addr,
    input  logic [63:0]       cfg_data,
    input  logic              start,
    input  logic [CTX_AW-1:0] ctx_last,
    input  logic [LOOP_W-1:0] loop_cnt,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [8:0]        control_in,
    output logic [8:0]        control_out,
    output logic [5:0]        control_put_in,
    output logic [5:0]        control_put_out,
    output logic [5:0]        control_send,
    output logic [5:0]        control_reg_1,
    output logic [5:0]        control_reg_2,
    output logic [3:0]        control_pe2fu_1,
    output logic [3:0]        control_pe2fu_2,
    output logic              write_back,
    output logic              ld,
    output logic              ld_write
`ifdef PE_CTX_ILLEGAL_CHK_EN
    ,
    output logic              ctx_illegal
`endif
);

    logic [63:0]       mem [CTX_DEPTH];
    state_t            state;
    logic [CTX_AW-1:0] pc, issued, last_idx;
    logic [LOOP_W-1:0] pass_left;
    ctx_bundle_t       out_q, dec;

    logic              addr_bad, wr_ok, at_last;
    logic [CTX_AW-1:0] rd_idx, last_in;
    logic [63:0]       rd_word;

    assign addr_bad = 32'(cfg_addr) >= CTX_DEPTH;
    assign wr_ok    = (state == IDLE) && cfg_we && !addr_bad;
    assign at_last  = issued == last_idx;
    assign rd_idx   = (state == RUN && !at_last) ? pc : '0;
    // Same-edge write to word 0 must be visible to a coincident start.
    assign rd_word  = (wr_ok && cfg_addr == '0 && rd_idx == '0) ? cfg_data : mem[rd_idx];
    assign last_in  = (32'(ctx_last) >= CTX_DEPTH) ? CTX_AW'(CTX_DEPTH - 1) : ctx_last;

`ifdef PE_CTX_ILLEGAL_CHK_EN
    logic dec_illegal;
    pe_ctx_decode u_dec (.word(rd_word), .bundle(dec), .illegal(dec_illegal));
`else
    pe_ctx_decode u_dec (.word(rd_word), .bundle(dec));
`endif

    always_ff @(posedge CLK) begin
        if (wr_ok) mem[cfg_addr] <= cfg_data;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            out_q     <= NOP_BUNDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            pc        <= '0;
            issued    <= '0;
            last_idx  <= '0;
            pass_left <= '0;
`ifdef PE_CTX_ILLEGAL_CHK_EN
            ctx_illegal <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cfg_err <= cfg_we && addr_bad;
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        out_q     <= dec;
                        issued    <= '0;
                        last_idx  <= last_in;
                        pass_left <= loop_cnt;
                        pc        <= (last_in == '0) ? '0 : CTX_AW'(1);
`ifdef PE_CTX_ILLEGAL_CHK_EN
                        ctx_illegal <= dec_illegal;
`endif
                    end
                end
                RUN: begin
                    cfg_err <= cfg_we;
                    if (!stall) begin
                        if (!at_last) begin
                            out_q  <= dec;
                            issued <= pc;
                            pc     <= pc + 1'b1;
`ifdef PE_CTX_ILLEGAL_CHK_EN
                            ctx_illegal <= dec_illegal;
`endif
                        end else if (pass_left != '0) begin
                            pass_left <= pass_left - 1'b1;
                            out_q     <= dec;
                            issued    <= '0;
                            pc        <= (last_idx == '0) ? '0 : CTX_AW'(1);
`ifdef PE_CTX_ILLEGAL_CHK_EN
                            ctx_illegal <= dec_illegal;
`endif
                        end else begin
                            state <= IDLE;
                            out_q <= NOP_BUNDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`ifdef PE_CTX_ILLEGAL_CHK_EN
                            ctx_illegal <= 1'b0;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign control_in      = out_q.control_in;
    assign control_out     = out_q.control_out;
    assign control_put_in  = out_q.put_in;
    assign control_put_out = out_q.put_out;
    assign control_send    = out_q.send;
    assign control_reg_1   = out_q.reg_1;
    assign control_reg_2   = out_q.reg_2;
    assign control_pe2fu_1 = out_q.pe2fu_1;
    assign control_pe2fu_2 = out_q.pe2fu_2;
    assign write_back      = out_q.write_back;
    assign ld              = out_q.ld;
    assign ld_write        = out_q.ld_write;

endmodule

// File: tb/tb_pe_ctx_seq.sv
// Scoreboard bench for pe_ctx_seq: stimulus pushes per-cycle expectations, a negedge monitor checks.
// The model replays the kernel as a flat list of (ctx_last+1)*(loop_cnt+1) words.
module tb_pe_ctx_seq;

    localparam int DEPTH = 12;
    localparam int AW    = 4;
    localparam int LW    = 8;
    localparam logic [58:0] NOP_V = 59'h1 << 57;

    logic          CLK = 1'b0, RST = 1'b1;
    logic          cfg_we = 1'b0, start = 1'b0, stall = 1'b0;
    logic [AW-1:0] cfg_addr = '0, ctx_last = '0;
    logic [63:0]   cfg_data = '0;
    logic [LW-1:0] loop_cnt = '0;
    logic          busy, done, cfg_err, write_back, ld, ld_write;
    logic [8:0]    control_in, control_out;
    logic [5:0]    control_put_in, control_put_out, control_send, control_reg_1, control_reg_2;
    logic [3:0]    control_pe2fu_1, control_pe2fu_2;
`ifdef PE_CTX_ILLEGAL_CHK_EN
    logic          ctx_illegal;
`endif

    pe_ctx_seq #(.CTX_DEPTH(DEPTH), .CTX_AW(AW), .LOOP_W(LW)) dut (
        .CLK(CLK), .RST(RST), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .ctx_last(ctx_last), .loop_cnt(loop_cnt), .stall(stall),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .control_in(control_in), .control_out(control_out),
        .control_put_in(control_put_in), .control_put_out(control_put_out),
        .control_send(control_send), .control_reg_1(control_reg_1), .control_reg_2(control_reg_2),
        .control_pe2fu_1(control_pe2fu_1), .control_pe2fu_2(control_pe2fu_2),
        .write_back(write_back), .ld(ld), .ld_write(ld_write)
`ifdef PE_CTX_ILLEGAL_CHK_EN
        , .ctx_illegal(ctx_illegal)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          cyc;
        logic [58:0] v;
        logic        busy, done, err;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          vectors = 0, miscompares = 0;
    bit          end_chk = 0;
    logic [63:0] mdl_mem [DEPTH];

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: compares every expectation whose cycle tag has arrived.
    always @(negedge CLK) begin
        exp_t        e;
        logic [58:0] act;
        act = {ld_write, ld, write_back, control_pe2fu_2, control_pe2fu_1, control_reg_2,
               control_reg_1, control_send, control_put_out, control_put_in, control_out, control_in};
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            vectors++;
            if ({act, busy, done, cfg_err} !== {e.v, e.busy, e.done, e.err}) begin
                miscompares++;
                $display("FAIL cycle%0d bundle: got v=%h busy=%b done=%b err=%b, want v=%h busy=%b done=%b err=%b",
                         cyc, act, busy, done, cfg_err, e.v, e.busy, e.done, e.err);
            end
        end
        if (end_chk) begin
            vectors++;
            if (exp_q.size() != 0) begin
                miscompares++;
                $display("FAIL drain: got %0d pending, want 0", exp_q.size());
            end
            end_chk = 0;
        end
    end

    task automatic push(input logic [58:0] v, input logic b, input logic d, input logic e);
        exp_t x;
        x.cyc = cyc + 1; x.v = v; x.busy = b; x.done = d; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        cfg_we = 0; start = 0; stall = 0; RST = 0;
    endtask

    task automatic idle(input bit we, input int addr, input logic [63:0] data);
        cfg_we = we; cfg_addr = AW'(addr); cfg_data = data;
        push(NOP_V, 0, 0, we && addr >= DEPTH);
        if (we && addr < DEPTH) mdl_mem[addr] = data;
        tick();
        clr();
    endtask

    // One kernel launch; abort_at>0 asserts RST on that run cycle instead of finishing.
    task automatic launch(input int last, input int loops, input int stall_pct, input int stall_k,
                          input int we_pct, input int abort_at, input bit we0);
        int n_ctx, eff, j, k;
        bit st, we;
        eff   = (last >= DEPTH) ? DEPTH - 1 : last;
        n_ctx = (eff + 1) * (loops + 1);
        start = 1; ctx_last = AW'(last); loop_cnt = LW'(loops);
        if (we0) begin
            cfg_we = 1; cfg_addr = 0; cfg_data = {$urandom, $urandom};
            mdl_mem[0] = cfg_data;
        end
        push(mdl_mem[0][58:0], 1, 0, 0);
        tick();
        clr();
        j = 0; k = 0;
        while (1) begin
            k++;
            st = (k >= stall_k && k < stall_k + 3) || ($urandom_range(99) < stall_pct);
            we = $urandom_range(99) < we_pct;
            stall = st; cfg_we = we; start = $urandom_range(1);
            cfg_addr = AW'($urandom_range(15)); cfg_data = {$urandom, $urandom};
            ctx_last = AW'($urandom_range(15)); loop_cnt = LW'($urandom_range(255));
            if (k == abort_at) begin
                RST = 1;
                push(NOP_V, 0, 0, 0);
                tick();
                break;
            end
            if (!st) j++;
            if (j == n_ctx) begin
                push(NOP_V, 0, 1, we);
                tick();
                break;
            end
            push(mdl_mem[j % (eff + 1)][58:0], 1, 0, we);
            tick();
        end
        clr();
        idle(0, 0, 0);
    endtask

    initial begin
        logic [63:0] w;
        tick(); tick();
        RST = 0;
        for (int i = 0; i < 10; i++) idle(0, 0, 0);
        for (int a = 0; a < DEPTH; a++) begin
            w = {$urandom, $urandom};
            w[23:18] = 6'(a + 1);
            idle(1, a, w);
        end
        idle(1, 13, 64'h1234);
        idle(1, 15, 64'h5678);
        launch(2, 0, 0, 99, 0, 0, 0);
        launch(2, 2, 0, 99, 0, 0, 0);
        launch(2, 0, 0, 2, 0, 0, 0);
        launch(2, 0, 0, 99, 100, 0, 0);
        launch(2, 0, 0, 99, 0, 0, 0);
        launch(5, 1, 0, 99, 0, 3, 0);
        launch(0, 3, 0, 99, 0, 0, 0);
        launch(14, 0, 0, 99, 0, 0, 0);
        launch(3, 0, 0, 99, 0, 0, 1);
        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(2) == 0) idle(1, $urandom_range(15), {$urandom, $urandom});
            launch($urandom_range(15), $urandom_range(3), 20, 99, 20,
                   ($urandom_range(4) == 0) ? $urandom_range(1, 10) : 0, $urandom_range(1));
        end
        tick(); tick();
        end_chk = 1;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

endmodule

// File: doc/pe_ctx_seq.md
Name: pe_ctx_seq

Overview:
- Upstream context sequencer for one PE. It stores a small program of 64-bit context words and replays one word per cycle.
- Each word is decoded into the control bundle the PE register-file stage consumes: input mux, register read/write addresses, FU operand selects, send/demux, write-back and load qualifiers.
- It supports a repeat count, a stall, and a done pulse, so a row/array controller can launch a PE kernel with one start pulse.

Parameters:
- CTX_DEPTH, 16, number of context words stored.
- CTX_AW, 4, context address width; must satisfy 2^CTX_AW >= CTX_DEPTH.
- LOOP_W, 8, width of the repeat counter.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- cfg_we  in  1  context write strobe.
- cfg_addr  in  CTX_AW  context write address.
- cfg_data  in  64  context word.
- start  in  1  launch pulse.
- ctx_last  in  CTX_AW  index of the last context of the kernel; latched on start.
- loop_cnt  in  LOOP_W  extra passes; total passes = loop_cnt+1; latched on start.
- stall  in  1  hold the current context, no advance.
- busy  out  1  high while RUN.
- done  out  1  one-cycle pulse after the last context is issued.
- cfg_err  out  1  one-cycle pulse when cfg_we is rejected.
- control_in  out  9  PE input-mux select.
- control_out  out  9  PE output demux enables.
- control_put_in, control_put_out, control_send, control_reg_1, control_reg_2  out  6 each  register addresses.
- control_pe2fu_1, control_pe2fu_2  out  4 each  FU operand source selects.
- write_back, ld, ld_write  out  1 each  write qualifiers.

Behaviour:
- Context word field map: [8:0] control_in; [17:9] control_out; [23:18] put_in; [29:24] put_out; [35:30] send; [41:36] reg_1; [47:42] reg_2; [51:48] pe2fu_1; [55:52] pe2fu_2; [56] write_back; [57] ld; [58] ld_write; [63:59] reserved, written and ignored.
- NOP bundle: all fields 0 except ld=1. With ld_write=0 and write_back=0 this causes no register-file change.
- All control outputs are registered and change only on posedge CLK. This gives the negedge-writing register file a half-cycle of setup.
- Reset:
  - State goes to IDLE.
  - Outputs take the NOP bundle; busy=0, done=0, cfg_err=0; pc=0.
  - Context memory is NOT cleared.
  - RST mid-RUN aborts immediately with no done pulse.
- IDLE:
  - cfg_we writes mem[cfg_addr]. Addresses >= CTX_DEPTH are dropped and pulse cfg_err.
  - On start: latch ctx_last and loop_cnt into pass_left; load the output register with mem[0]; set pc=1 (pc=0 if ctx_last=0); go to RUN; busy=1 from the same edge.
  - If start and cfg_we arrive together, the write completes first and start reads the updated mem[0].
- RUN:
  - stall=1: outputs, pc and pass_left hold. The same context stays driven (re-issued).
  - stall=0 and the currently issued context index != ctx_last: issue mem[pc]; pc advances.
  - Issued context index == ctx_last and pass_left>0: pass_left decrements; issue mem[0]; pc wraps to 1.
  - Issued context index == ctx_last and pass_left==0: outputs go to NOP; busy=0; done=1 for exactly one cycle; go to IDLE.
  - start during RUN is ignored. cfg_we during RUN is ignored and pulses cfg_err.
- Latency: start edge k drives mem[0] after edge k. An unstalled run of (ctx_last+1)*(loop_cnt+1) contexts ends with done high for the cycle after the final context.
- ctx_last >= CTX_DEPTH is clamped to CTX_DEPTH-1 at latch.

Optional Feature:
- Macro PE_CTX_ILLEGAL_CHK_EN.
- Defined: each word is checked at issue.
  - control_in must be one of 0, 9'h008, 9'h004, 9'h002, 9'h010.
  - Each pe2fu field must be one of 4'b0000, 0010, 0011, 0100, 1000.
  - An illegal word is replaced by the NOP bundle, and an extra output ctx_illegal (1 bit) pulses for that cycle. Sequencing continues.
- Undefined: no check, no ctx_illegal port; words are driven verbatim.

Decomposition:
- Package pe_ctx_pkg holds:
  - field LSB/MSB constants;
  - legal control_in and pe2fu code constants;
  - state enum IDLE/RUN;
  - the NOP bundle constant.
- One natural sub-module: pe_ctx_decode, a combinational unpack of a 64-bit word to the bundle, including the legality check.

Test Plan:
- Reset then idle: outputs equal NOP (ld=1, rest 0), busy=0 for 10 cycles; cfg_err=0.
- Load mem[0..2] with distinct put_in 1/2/3; start with ctx_last=2, loop_cnt=0 -> put_in 1,2,3 on consecutive cycles, then NOP with done=1 for one cycle.
- Same program, loop_cnt=2 -> sequence 1,2,3 repeated 3 times (9 cycles), a single done pulse, busy high for exactly 9 cycles.
- stall high for 3 cycles while put_in=2 -> put_in stays 2 for 4 cycles total, then 3; done is delayed by 3 cycles.
- cfg_we during RUN to addr 0 -> cfg_err pulses and mem[0] is unchanged on the next run. RST asserted mid-run -> next cycle NOP, busy=0, no done.
- With PE_CTX_ILLEGAL_CHK_EN: a word with control_in=9'h003 -> NOP issued, ctx_illegal=1 for that cycle only, next context issued normally.
